// File: rtl/spi_miso_tx.sv
// SPI slave transmit path for the display register block.
// Returns a status byte in the command slot of every 16-bit frame and, for
// register-read commands, the addressed register in the value slot.
// All state is clocked by the gated SPI clock, so nothing advances while SS
// is high; frame alignment after a partial frame is recovered only by reset.
module spi_miso_tx #(
  parameter int          BYTE_WIDTH    = 8,
  parameter int          NUM_REGISTERS = 10,
  parameter logic [3:0]  READ_CMD      = 4'b0010
) (
  input  logic                  rst_low_i,
  input  logic                  spi_rx_clk_c,
  input  logic                  spi_ss_i,
  input  logic                  spi_mosi_i,
  input  logic [BYTE_WIDTH-1:0] rd_data_i,
  output logic [3:0]            rd_addr_o,
  output logic                  spi_miso_o
);

  // Frame slots, decoded straight from the bit counter:
  //   state     | meaning
  //   CMD_SLOT  | count 0..7, command byte arriving, status byte leaving
  //   RESP_SLOT | count 8..15, value byte arriving, response byte leaving
  typedef enum logic {
    CMD_SLOT  = 1'b0,
    RESP_SLOT = 1'b1
  } slot_t;

  localparam logic [4:0] NUM_REGS_L = 5'(NUM_REGISTERS);
  localparam logic [3:0] LAST_CMD_BIT = 4'd7;
  localparam logic [3:0] LAST_BIT     = 4'd15;

  logic [3:0]            bit_cnt_r;
  // Only the seven most recent command bits are ever needed: the eighth
  // arrives on spi_mosi_i at the decode edge itself.
  logic [BYTE_WIDTH-2:0] cmd_shift_r;
  logic [BYTE_WIDTH-1:0] tx_shift_r;
  logic [3:0]            rd_count_r;
  logic [3:0]            last_cmd_r;

  slot_t                 slot;
  logic [BYTE_WIDTH-1:0] cmd_byte;
  logic [3:0]            cmd_nibble;
  logic                  is_read;
  logic                  addr_in_range;
  logic                  at_cmd_edge;
  logic                  at_frame_edge;
  logic [BYTE_WIDTH-1:0] status_byte;
  logic [BYTE_WIDTH-1:0] resp_byte;
  logic [BYTE_WIDTH-1:0] tx_next;

  assign slot          = bit_cnt_r[3] ? RESP_SLOT : CMD_SLOT;
  assign at_cmd_edge   = (bit_cnt_r == LAST_CMD_BIT);
  assign at_frame_edge = (bit_cnt_r == LAST_BIT);

  assign cmd_byte      = {cmd_shift_r, spi_mosi_i};
  assign cmd_nibble    = cmd_byte[BYTE_WIDTH-1 -: 4];
  assign rd_addr_o     = cmd_byte[3:0];
  assign is_read       = (cmd_nibble == READ_CMD);
  assign addr_in_range = ({1'b0, rd_addr_o} < NUM_REGS_L);

  // Nothing moves the bookkeeping between the decode edge and the frame
  // edge, so the registered values already describe the finished frame.
  assign status_byte = BYTE_WIDTH'({rd_count_r, last_cmd_r});

  assign spi_miso_o = spi_ss_i ? 1'b1 : tx_shift_r[BYTE_WIDTH-1];

  // Response byte chosen at the command decode edge.
  always_comb begin
    resp_byte = '0;
    if (is_read) begin
      resp_byte = addr_in_range ? rd_data_i : '1;
    end
  end

  // Next transmit shifter value: shift by default, reload at slot boundaries.
  always_comb begin
    tx_next = {tx_shift_r[BYTE_WIDTH-2:0], 1'b0};
    if (at_cmd_edge) begin
      tx_next = resp_byte;
    end else if (at_frame_edge) begin
      tx_next = status_byte;
    end
  end

  // Frame counter, command capture, transmit shifter and status bookkeeping.
  always_ff @(posedge spi_rx_clk_c or negedge rst_low_i) begin
    if (!rst_low_i) begin
      bit_cnt_r   <= '0;
      cmd_shift_r <= '0;
      tx_shift_r  <= '0;
      rd_count_r  <= '0;
      last_cmd_r  <= '0;
    end else begin
      bit_cnt_r  <= bit_cnt_r + 4'd1;
      tx_shift_r <= tx_next;
      if (slot == CMD_SLOT) begin
        cmd_shift_r <= cmd_byte[BYTE_WIDTH-2:0];
      end
      if (at_cmd_edge) begin
        last_cmd_r <= cmd_nibble;
        if (is_read) begin
          rd_count_r <= rd_count_r + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_miso_tx.sv
// Directed bench for spi_miso_tx: a master task clocks 16-bit frames and
// pushes the hand-computed reply into a scoreboard queue; a monitor pops and
// compares each time a completed frame is handed over.
module tb_spi_miso_tx;

  typedef struct {
    logic [7:0] up;
    logic [7:0] lo;
    logic [3:0] addr;
    string      name;
  } exp_t;

  logic       rst_low;
  logic       spi_clk;
  logic       ss;
  logic       mosi;
  logic [7:0] rd_data;
  logic [3:0] rd_addr;
  logic       miso;

  int total = 0;
  int bad   = 0;

  exp_t       exp_q[$];
  logic [15:0] rx_word;
  logic [3:0]  rx_addr;
  int          frames_done = 0;

  spi_miso_tx dut (
    .rst_low_i    (rst_low),
    .spi_rx_clk_c (spi_clk),
    .spi_ss_i     (ss),
    .spi_mosi_i   (mosi),
    .rd_data_i    (rd_data),
    .rd_addr_o    (rd_addr),
    .spi_miso_o   (miso)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic run_frame(input logic [7:0] cmd, input logic [7:0] val, input logic [7:0] rdata,
                           input logic [7:0] exp_up, input logic [7:0] exp_lo, input string name);
    logic [15:0] word;
    logic [15:0] rx;
    logic [3:0]  got_addr;
    exp_t e;
    e.up = exp_up; e.lo = exp_lo; e.addr = cmd[3:0]; e.name = name;
    exp_q.push_back(e);
    word = {cmd, val};
    rx = '0;
    got_addr = '0;
    rd_data = rdata;
    ss = 1'b0;
    #5;
    for (int c = 1; c <= 16; c++) begin
      mosi = word[16-c];
      #2;
      rx[16-c] = miso;
      if (c == 8) got_addr = rd_addr;
      #3 spi_clk = 1'b1;
      #5 spi_clk = 1'b0;
    end
    #5 ss = 1'b1;
    rx_word = rx;
    rx_addr = got_addr;
    frames_done++;
    #10;
  endtask

  task automatic pulse_reset();
    #2 rst_low = 1'b0;
    #5 rst_low = 1'b1;
    #5;
  endtask

  // Scoreboard monitor.
  initial begin
    exp_t e;
    forever begin
      @(frames_done);
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_underflow: got frame 0x%0h with nothing expected", rx_word);
      end else begin
        e = exp_q.pop_front();
        check({e.name, "_status"}, {8'h00, rx_word[15:8]}, {8'h00, e.up});
        check({e.name, "_resp"},   {8'h00, rx_word[7:0]},  {8'h00, e.lo});
        check({e.name, "_addr"},   {12'h000, rx_addr},     {12'h000, e.addr});
      end
    end
  end

  // Watchdog.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_low = 1'b0;
    spi_clk = 1'b0;
    ss      = 1'b1;
    mosi    = 1'b0;
    rd_data = 8'h00;
    #3;
    check("reset_ss_high_miso", {15'h0, miso}, 16'h0001);
    ss = 1'b0;
    #1;
    check("reset_ss_low_miso", {15'h0, miso}, 16'h0000);
    ss = 1'b1;
    #10 rst_low = 1'b1;
    #10;

    run_frame(8'h00, 8'h00, 8'h33, 8'h00, 8'h00, "idle");
    run_frame(8'h23, 8'h00, 8'h5A, 8'h00, 8'h5A, "read3");
    run_frame(8'h14, 8'h07, 8'h77, 8'h12, 8'h00, "write");
    run_frame(8'h2C, 8'h00, 8'h66, 8'h11, 8'hFF, "read_oor");
    run_frame(8'h00, 8'h00, 8'h00, 8'h22, 8'h00, "after_oor");
    run_frame(8'h29, 8'h00, 8'hC3, 8'h20, 8'hC3, "read9_edge");
    run_frame(8'h2A, 8'h00, 8'hC3, 8'h32, 8'hFF, "read10_edge");

    pulse_reset();
    for (int i = 0; i < 16; i++) begin
      run_frame(8'h20, 8'h00, 8'hA5, (i == 0) ? 8'h00 : {4'(i), 4'h2}, 8'hA5, $sformatf("burst%0d", i));
    end
    run_frame(8'h00, 8'h00, 8'h00, 8'h02, 8'h00, "burst_wrap");

    // Partial frame interrupted by reset after five edges.
    rd_data = 8'h00;
    ss = 1'b0;
    #5;
    for (int c = 1; c <= 5; c++) begin
      mosi = 1'b1;
      #5 spi_clk = 1'b1;
      #5 spi_clk = 1'b0;
    end
    #2 rst_low = 1'b0;
    #3;
    check("mid_reset_miso", {15'h0, miso}, 16'h0000);
    #5 rst_low = 1'b1;
    #5 ss = 1'b1;
    #10;
    run_frame(8'h23, 8'h00, 8'h5A, 8'h00, 8'h5A, "post_reset_read");
    run_frame(8'h00, 8'h00, 8'h00, 8'h12, 8'h00, "post_reset_status");

    #20;
    check("sb_drain", 16'(exp_q.size()), 16'h0000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_miso_tx.md
Name: spi_miso_tx

Overview:
- SPI slave transmit path for the Nexys4 display register block. Drives spi_miso_o, the return direction of the existing 16-bit command channel.
- Runs on the gated SPI clock spi_rx_clk_c, which rises on each active SCLK edge while SS is low.
- Frame format is unchanged: upper byte is command, lower byte is value.
- Command nibble 4'b0010 is a register read. The addressed register is returned in the lower-byte slot of the same frame. Every frame's upper-byte slot returns a status byte.

Parameters:
- BYTE_WIDTH, 8, width of SPI byte, data and status bytes
- NUM_REGISTERS, 10, number of readable registers (addresses 0..NUM_REGISTERS-1)
- READ_CMD, 4'b0010, command nibble that selects a register read

Ports:
- rst_low_i  input  1  asynchronous active-low reset
- spi_rx_clk_c  input  1  clock: gated SPI clock, posedge active
- spi_ss_i  input  1  slave select, idle high; gates spi_miso_o only
- spi_mosi_i  input  1  master-out data, sampled on posedge spi_rx_clk_c
- rd_data_i  input  8  register contents at rd_addr_o; must be stable from posedge 7 to posedge 8 of the frame
- rd_addr_o  output  4  combinational read address = {cmd_shift_r[2:0], spi_mosi_i}
- spi_miso_o  output  1  = spi_ss_i ? 1'b1 : tx_shift_r[7]

Behaviour:
- Interface: reset rst_low_i, asynchronous, active-low; clock spi_rx_clk_c. All state lives in this single domain.
- Reset values: bit_cnt_r=0, cmd_shift_r=8'h00, tx_shift_r=8'h00, rd_count_r=0, last_cmd_r=0. spi_miso_o is therefore 1 when SS is high and 0 when SS is low.
- bit_cnt_r, 4 bits: increments on every posedge and wraps 15->0. Let c denote the posedge number in the frame, 1..16; posedge 16 returns the count to 0.
- cmd_shift_r: shifts in spi_mosi_i, MSB first, on posedges 1..8. It holds its value on posedges 9..16.
- Full command byte at posedge 8 = {cmd_shift_r[6:0], spi_mosi_i}. It is decoded combinationally at that edge.
- The frame FSM is implicit in the count:
  - CMD_SLOT (count 0..7): transmits the status byte.
  - RESP_SLOT (count 8..15): transmits the response byte.
- Bit timing: the master samples MISO on posedge c and receives the bit presented after posedge c-1. Byte MSB is presented after posedges 16/0 and 8.
- tx_shift_r update rules:
  - Posedges 1..7 and 9..15: shift left, LSB filled with 0.
  - Posedge 8, command nibble == READ_CMD and address < NUM_REGISTERS: load rd_data_i.
  - Posedge 8, command nibble == READ_CMD and address >= NUM_REGISTERS: load 8'hFF.
  - Posedge 8, any other command: load 8'h00.
  - Posedge 16: load status byte {rd_count_next[3:0], last_cmd_next[3:0]}.
- Status bookkeeping:
  - last_cmd_r <= command nibble at posedge 8.
  - rd_count_r increments (mod 16) at posedge 8 when the nibble is READ_CMD, including out-of-range addresses.
  - The status byte loaded at posedge 16 reflects the frame just completed.
- First frame after reset transmits status 8'h00.
- rd_addr_o is valid only during the bit-8 window. Outside that window its value is don't-care and must not be used.
- Simultaneous events:
  - Read and wrap of rd_count_r at 15 gives 0.
  - Reset asserted mid-frame clears all state immediately; the next posedge counts as bit 1.
- SS abort mid-frame: state is held, because no clock runs while SS is high. Alignment is restored only by rst_low_i. Partial frames are a master protocol error.
- No writes are performed here. Write frames (nibble 0001) only update last_cmd_r and return 8'h00.

Test Plan:
- Reset, SS high -> spi_miso_o=1. Frame 0x00,0x00 -> MISO bytes 0x00,0x00.
- Frame 0x23,0x00 with rd_data_i=0x5A when rd_addr_o=3 -> rd_addr_o=3 at bit 8; MISO lower byte 0x5A. Next frame upper MISO byte 0x12.
- Write frame 0x14,0x07 after one read -> MISO lower byte 0x00. Next status 0x11 (rd_count=1, last_cmd=1).
- Read frame 0x2C,0x00 (address 12 >= 10) -> MISO lower byte 0xFF. rd_count still increments.
- 16 consecutive reads of addr 0 (rd_data_i=0xA5) -> each lower byte 0xA5. Status after the 16th = 0x02 (count wrapped to 0).
- rst_low_i pulsed after 5 posedges of a frame -> bit_cnt_r=0, MISO=0. Following full frame 0x23 decodes correctly, with status 0x00.
